bist_jtag_dr: RTL and testbench

- JTAG test-data register and run sequencer that sits directly upstream of the BIST block.
- Shifts the 16-bit BIST command word in from the TAP and holds it in a shadow register; that register drives the BIST block's From_BIST_reg.
- Generates the BIST block's BIST_clk_en and BIST_res, and decides when a run has ended.
- Captures the BIST block's To_BIST_reg so it can be shifted back out on TDO.

---
 rtl/bist_pkg.sv | 32 +++
 rtl/bist_run_seq.sv | 112 +++++++++++
 rtl/bist_jtag_dr.sv | 108 ++++++++++
 tb/tb_bist_jtag_dr.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
//   Shared definitions for the BIST JTAG data register and its run sequencer.
//   - DR_W       : width of the JTAG shift register and the shadow register.
//   - IDLE_CODE  : To_BIST_reg value meaning "no error written".
//   - MODE_HI/LO : bit range of the mode field inside the command word.
//   - CNT_W      : width of the sequencer phase counter.
//   - run_state_t: sequencer state encoding.
// -----------------------------------------------------------------------------
package bist_pkg;

  localparam int DR_W    = 16;
  localparam int MODE_HI = 15;
  localparam int MODE_LO = 12;
  localparam int MODE_W  = MODE_HI - MODE_LO + 1;
  localparam int CNT_W   = 12;

  localparam logic [DR_W-1:0] IDLE_CODE = 16'hF000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_t;

  // Mode field of a command word; zero means "stop / do not run".
  function automatic logic [MODE_W-1:0] mode_of(input logic [DR_W-1:0] word);
    return word[MODE_HI:MODE_LO];
  endfunction

endpackage

// File: rtl/bist_run_seq.sv
// -----------------------------------------------------------------------------
// bist_run_seq
//   Run sequencer for the BIST block: IDLE -> RESET -> RUN -> DONE.
//   RESET holds the BIST block in reset (with its clock enabled so the
//   synchronous reset takes effect) for RES_CYCLES cycles; RUN lets it work
//   for at most RUN_CYCLES cycles, ending early when an error code appears.
//
//   Ports:
//     clk, res      : clock, synchronous active-high reset
//     start         : single-cycle request to (re)start a run
//     abort         : single-cycle request to stop and return to IDLE
//     result        : BIST block result word (its To_BIST_reg)
//     state, cnt    : current state and phase counter (debug visibility)
//     bist_clk_en   : clock enable for the BIST block
//     bist_res      : reset for the BIST block
//     busy          : RESET or RUN in progress
//     done          : last run finished, sticky until start/abort/reset
//     pass          : valid with done; 1 = full run with no error code
//
//   start and abort are mutually exclusive strobes from the top level; start
//   wins if both were ever raised together.
// -----------------------------------------------------------------------------
module bist_run_seq
  import bist_pkg::*;
#(
  parameter int RES_CYCLES = 4,
  parameter int RUN_CYCLES = 512
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             abort,
  input  logic [DR_W-1:0]  result,
  output run_state_t       state,
  output logic [CNT_W-1:0] cnt,
  output logic             bist_clk_en,
  output logic             bist_res,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RES_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

  // Registered copy of (state == ST_RESET); bist_res additionally follows
  // the system reset combinationally so the BIST block is reset with us.
  logic in_reset;

  assign bist_res = res | in_reset;

  always_ff @(posedge clk) begin
    if (res) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      in_reset    <= 1'b0;
      bist_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else if (start) begin
      // Restart from any state, including a run already in progress.
      state       <= ST_RESET;
      cnt         <= '0;
      in_reset    <= 1'b1;
      bist_clk_en <= 1'b1;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else if (abort) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      in_reset    <= 1'b0;
      bist_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          if (cnt == RES_LAST) begin
            state    <= ST_RUN;
            cnt      <= '0;
            in_reset <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          // An error code ends the run even on its last cycle.
          if (result != IDLE_CODE) begin
            state       <= ST_DONE;
            bist_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
          end else if (cnt == RUN_LAST) begin
            state       <= ST_DONE;
            bist_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE hold until a start, abort or reset.
        end
      endcase
    end
  end

endmodule

// File: rtl/bist_jtag_dr.sv
// -----------------------------------------------------------------------------
// bist_jtag_dr
//   JTAG test-data register in front of the BIST block. A DR_W-bit shift
//   register is loaded from the TAP (LSB first) or from the BIST result, and
//   an Update-DR copies it into the shadow register that drives the BIST
//   block's From_BIST_reg and starts (mode != 0) or aborts (mode == 0) a run.
//
//   Ports:
//     clk, res        : clock, synchronous active-high reset
//     tdi, tdo        : serial data from / to the TAP (tdo = sr[0])
//     sel_bist        : BIST instruction selected; qualifies all DR strobes
//     capture_dr      : Capture-DR strobe, sr <= to_bist_reg
//     shift_dr        : Shift-DR enable, one bit per cycle
//     update_dr       : Update-DR strobe, from_bist_reg <= sr
//     to_bist_reg     : BIST block result word
//     from_bist_reg   : shadow command word to the BIST block
//     bist_clk_en     : BIST block clock enable
//     bist_res        : BIST block reset
//     busy, done, pass: run status
//     dbg_state       : sequencer state (IDLE=0, RESET=1, RUN=2, DONE=3)
//     dbg_cnt         : sequencer phase counter
//
//   Strobe protocol: the TAP strobes carry no handshake. Each is sampled on
//   the rising clk edge while sel_bist = 1 and acts in that edge; when
//   several coincide, capture beats shift and shift beats update.
// -----------------------------------------------------------------------------
module bist_jtag_dr
  import bist_pkg::*;
#(
  parameter int RES_CYCLES = 4,
  parameter int RUN_CYCLES = 512
) (
  input  logic             clk,
  input  logic             res,
  input  logic             tdi,
  output logic             tdo,
  input  logic             sel_bist,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic [DR_W-1:0]  to_bist_reg,
  output logic [DR_W-1:0]  from_bist_reg,
  output logic             bist_clk_en,
  output logic             bist_res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  logic [DR_W-1:0] sr;
  logic            do_capture;
  logic            do_shift;
  logic            do_update;
  logic            start;
  logic            abort;
  run_state_t      state;

  // Priority-resolved strobes.
  assign do_capture = sel_bist & capture_dr;
  assign do_shift   = sel_bist & shift_dr & ~capture_dr;
  assign do_update  = sel_bist & update_dr & ~capture_dr & ~shift_dr;

  // The mode is taken from sr, i.e. the value being copied into the shadow.
  assign start = do_update & (mode_of(sr) != '0);
  assign abort = do_update & (mode_of(sr) == '0);

  assign tdo       = sr[0];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (res) begin
      sr            <= '0;
      from_bist_reg <= '0;
    end else begin
      if (do_capture) begin
        sr <= to_bist_reg;
      end else if (do_shift) begin
        sr <= {tdi, sr[DR_W-1:1]};
      end
      // The shadow only moves on update, so shifting during a run never
      // disturbs the BIST block.
      if (do_update) begin
        from_bist_reg <= sr;
      end
    end
  end

  bist_run_seq #(
    .RES_CYCLES (RES_CYCLES),
    .RUN_CYCLES (RUN_CYCLES)
  ) u_run_seq (
    .clk         (clk),
    .res         (res),
    .start       (start),
    .abort       (abort),
    .result      (to_bist_reg),
    .state       (state),
    .cnt         (dbg_cnt),
    .bist_clk_en (bist_clk_en),
    .bist_res    (bist_res),
    .busy        (busy),
    .done        (done),
    .pass        (pass)
  );

endmodule

// File: tb/tb_bist_jtag_dr.sv
// -----------------------------------------------------------------------------
// tb_bist_jtag_dr
//   Self-checking bench for bist_jtag_dr. Every cycle the stimulus side
//   computes the outputs it expects from a run-level reference model (time
//   since the starting update, done/pass flags) and pushes them into exp_q;
//   a monitor on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_bist_jtag_dr;

  localparam int RES_CYCLES = 4;
  localparam int RUN_CYCLES = 512;
  localparam logic [15:0] NO_ERR = 16'hF000;
  // {from(16), tdo, clk_en, bres, busy, done, pass, state(2), cnt_chk, cnt(12)}
  localparam int W = 37;

  // ---------------- clock / reset ----------------
  logic clk;
  logic res;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic        tdi, tdo, sel_bist, capture_dr, shift_dr, update_dr;
  logic [15:0] to_bist_reg, from_bist_reg;
  logic        bist_clk_en, bist_res, busy, done, pass;
  logic [1:0]  dbg_state;
  logic [11:0] dbg_cnt;

  bist_jtag_dr #(
    .RES_CYCLES (RES_CYCLES),
    .RUN_CYCLES (RUN_CYCLES)
  ) dut (
    .clk           (clk),
    .res           (res),
    .tdi           (tdi),
    .tdo           (tdo),
    .sel_bist      (sel_bist),
    .capture_dr    (capture_dr),
    .shift_dr      (shift_dr),
    .update_dr     (update_dr),
    .to_bist_reg   (to_bist_reg),
    .from_bist_reg (from_bist_reg),
    .bist_clk_en   (bist_clk_en),
    .bist_res      (bist_res),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .dbg_state     (dbg_state),
    .dbg_cnt       (dbg_cnt)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_sr, m_shadow;
  bit          m_active;   // a run is in progress (reset or run phase)
  bit          m_done, m_pass, known;
  int          m_since;    // edges since the update that started the run

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [W-1:0] expected();
    logic       rst_ph, run_ph;
    logic [1:0] st;
    logic [11:0] c;
    rst_ph = m_active && (m_since <= RES_CYCLES);
    run_ph = m_active && (m_since > RES_CYCLES);
    st = rst_ph ? 2'd1 : run_ph ? 2'd2 : m_done ? 2'd3 : 2'd0;
    c  = rst_ph ? 12'(m_since - 1) : run_ph ? 12'(m_since - RES_CYCLES - 1) : 12'd0;
    return {m_shadow, m_sr[0], m_active, res | rst_ph, m_active, m_done, m_pass,
            st, m_active, c};
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [15:0] old;
    old = m_sr;
    if (res) begin
      m_sr = '0; m_shadow = '0; m_active = 0; m_done = 0; m_pass = 0; known = 1;
      return;
    end
    if (sel_bist && capture_dr) begin
      m_sr = to_bist_reg;
    end else if (sel_bist && shift_dr) begin
      m_sr = {tdi, m_sr[15:1]};
    end else if (sel_bist && update_dr) begin
      m_shadow = old;
      m_done = 0;
      if (old[15:12] != 4'd0) begin
        m_active = 1; m_since = 1; m_pass = 0;
      end else begin
        m_active = 0;
      end
      return;
    end
    if (m_active) begin
      if (m_since <= RES_CYCLES) begin
        m_since++;
      end else if (to_bist_reg != NO_ERR) begin
        m_active = 0; m_done = 1; m_pass = 0;
      end else if (m_since - RES_CYCLES - 1 == RUN_CYCLES - 1) begin
        m_active = 0; m_done = 1; m_pass = 1;
      end else begin
        m_since++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    if (known) exp_q.push_back(expected());
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic shift_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      shift_dr = 1'b1;
      tdi = w[i];
      tick();
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic capture();
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
  endtask

  task automatic update();
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  task automatic load_and_go(input logic [15:0] w);
    shift_word(w);
    update();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {from_bist_reg, tdo, bist_clk_en, bist_res, busy, done, pass,
             dbg_state, e[12], (e[12] ? dbg_cnt : 12'd0)};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL cycle_outputs t=%0t got from=%h tdo=%b en=%b bres=%b busy=%b done=%b pass=%b st=%0d cnt=%0d | expected from=%h tdo=%b en=%b bres=%b busy=%b done=%b pass=%b st=%0d cnt=%0d",
                   $time, a[36:21], a[20], a[19], a[18], a[17], a[16], a[15], a[14:13], a[11:0],
                   e[36:21], e[20], e[19], e[18], e[17], e[16], e[15], e[14:13], e[11:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    res = 1'b1; tdi = 1'b0; sel_bist = 1'b1;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    to_bist_reg = NO_ERR;
    m_sr = '0; m_shadow = '0; m_active = 0; m_done = 0; m_pass = 0; m_since = 0;
    known = 0;
    @(posedge clk);
    #1;

    // Reset for two cycles.
    tick();
    tick();
    res = 1'b0;

    // Capture 16'h1234 and shift it out LSB first while loading 16'h1000.
    to_bist_reg = 16'h1234;
    capture();
    to_bist_reg = NO_ERR;
    shift_word(16'h1000);
    idle(2);

    // Normal passing run.
    update();
    idle(RES_CYCLES + RUN_CYCLES + 4);

    // Error code during RUN, then read it back through the shift register.
    load_and_go(16'h2000);
    idle(RES_CYCLES + 37);
    to_bist_reg = 16'h0305;
    tick();
    idle(2);
    capture();
    to_bist_reg = NO_ERR;
    shift_word(16'($urandom));

    // Error on the last RUN cycle must still fail the run.
    load_and_go(16'h1000);
    idle(RES_CYCLES + RUN_CYCLES - 1);
    to_bist_reg = 16'h0001;
    tick();
    to_bist_reg = NO_ERR;
    idle(3);

    // Abort during RUN.
    load_and_go(16'h1000);
    idle(RES_CYCLES + 10);
    load_and_go(16'h0000);
    idle(5);

    // Restart during RUN.
    load_and_go(16'h1000);
    idle(RES_CYCLES + 20);
    load_and_go(16'h3000);
    idle(RES_CYCLES + 30);

    // Strobe priority: capture beats shift, shift beats update.
    to_bist_reg = 16'hA5A5;
    capture_dr = 1'b1; shift_dr = 1'b1; tdi = 1'b1;
    tick();
    capture_dr = 1'b0; tdi = 1'b0;
    update_dr = 1'b1;
    tick();
    shift_dr = 1'b0; update_dr = 1'b0;
    to_bist_reg = NO_ERR;
    idle(2);

    // Strobes ignored without sel_bist.
    sel_bist = 1'b0;
    to_bist_reg = 16'h5A5A;
    capture_dr = 1'b1; tick(); capture_dr = 1'b0;
    shift_dr = 1'b1; tdi = 1'b1; tick(); shift_dr = 1'b0; tdi = 1'b0;
    update_dr = 1'b1; tick(); update_dr = 1'b0;
    sel_bist = 1'b1;
    to_bist_reg = NO_ERR;
    idle(2);

    // Synchronous reset in the middle of RUN.
    load_and_go(16'h1000);
    idle(RES_CYCLES + 50);
    res = 1'b1;
    tick();
    res = 1'b0;
    idle(3);

    // Randomized traffic: busy TAP first, then sparse updates so runs finish.
    for (int phase = 0; phase < 2; phase++) begin
      repeat (3000) begin
        sel_bist    = ($urandom_range(0, 9) != 0);
        capture_dr  = ($urandom_range(0, 15) == 0);
        shift_dr    = ($urandom_range(0, 3) == 0);
        update_dr   = (phase == 0) ? ($urandom_range(0, 40) == 0)
                                   : ($urandom_range(0, 700) == 0);
        tdi         = 1'($urandom);
        to_bist_reg = ($urandom_range(0, 299) == 0) ? 16'($urandom) : NO_ERR;
        res         = ($urandom_range(0, 999) == 0);
        tick();
      end
    end
    res = 1'b0; sel_bist = 1'b1; capture_dr = 1'b0; shift_dr = 1'b0;
    update_dr = 1'b0; tdi = 1'b0; to_bist_reg = NO_ERR;
    idle(2);

    // Let the monitor drain the last entry.
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got %0d pending entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
